bram_s8_to_s2_reader: RTL

Read engine for the 512x8 side of the 2/8-bit dual-port block RAM. It accepts a base address and byte count, drives the RAM's synchronous 8-bit read port and absorbs the RAM's one-cycle output latency. It serializes each byte into four 2-bit symbols on a valid/ready stream, in the same bit order the 2-bit port uses. The block sits between the block RAM and any 2-bit symbol consumer, giving a full-rate 2-bit view of data written through the 8-bit port.

---
 rtl/bram_s8_to_s2_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bram_s8_to_s2_reader.sv
// Read engine for the 8-bit side of the 2/8-bit block RAM: fetches LEN bytes from
// BASE_ADDR and serializes each into four 2-bit symbols, LSB pair first.
module bram_s8_to_s2_reader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [8:0] base_addr_i,
  input  logic [9:0] len_i,
  output logic       busy_o,
  output logic       ram_en_o,
  output logic       ram_we_o,
  output logic       ram_rst_o,
  output logic [8:0] ram_addr_o,
  input  logic [7:0] ram_do_i,
  output logic [1:0] dout_o,
  output logic       dout_valid_o,
  input  logic       dout_ready_i,
  output logic       dout_last_o
);

  logic        busy_q, busy_d;
  logic [9:0]  fetch_left_q, fetch_left_d;
  logic [8:0]  next_addr_q, next_addr_d;
  logic        ram_en_q, ram_en_d;
  logic [8:0]  ram_addr_q, ram_addr_d;
  logic        rd_valid_q, rd_valid_d;
  logic        pf_valid_q, pf_valid_d;
  logic [7:0]  pf_data_q, pf_data_d;
  logic        sh_valid_q, sh_valid_d;
  logic [7:0]  sh_data_q, sh_data_d;
  logic [1:0]  sh_idx_q, sh_idx_d;
  logic [11:0] sym_left_q, sym_left_d;

  logic xfer, sh_load, accept, issue, last_xfer;

  assign xfer      = sh_valid_q & dout_ready_i;
  assign sh_load   = ~sh_valid_q | (xfer & (sh_idx_q == 2'd3));
  assign accept    = start_i & ~busy_q & (len_i != 10'd0);
  // rd_valid_q marks the cycle RAM_DO carries the byte requested one cycle earlier.
  assign issue     = busy_q & (fetch_left_q != 10'd0) & ~ram_en_q & ~rd_valid_q &
                     (~pf_valid_q | sh_load);
  assign last_xfer = xfer & (sym_left_q == 12'd1);

  always_comb begin
    busy_d       = busy_q;
    fetch_left_d = fetch_left_q;
    next_addr_d  = next_addr_q;
    ram_en_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    rd_valid_d   = ram_en_q;
    pf_valid_d   = pf_valid_q;
    pf_data_d    = pf_data_q;
    sh_valid_d   = sh_valid_q;
    sh_data_d    = sh_data_q;
    sh_idx_d     = sh_idx_q;
    sym_left_d   = sym_left_q;

    if (accept) begin
      busy_d       = 1'b1;
      ram_en_d     = 1'b1;
      ram_addr_d   = base_addr_i;
      next_addr_d  = base_addr_i + 9'd1;
      fetch_left_d = len_i - 10'd1;
      sym_left_d   = {len_i, 2'b00};
    end else if (issue) begin
      ram_en_d     = 1'b1;
      ram_addr_d   = next_addr_q;
      next_addr_d  = next_addr_q + 9'd1;
      fetch_left_d = fetch_left_q - 10'd1;
    end

    if (xfer) begin
      sym_left_d = sym_left_q - 12'd1;
      sh_data_d  = {2'b00, sh_data_q[7:2]};
      sh_idx_d   = sh_idx_q + 2'd1;
    end
    if (last_xfer) begin
      busy_d = 1'b0;
    end

    // Shift register refills from prefetch first so byte order is preserved.
    if (sh_load) begin
      sh_idx_d = 2'd0;
      if (pf_valid_q) begin
        sh_valid_d = 1'b1;
        sh_data_d  = pf_data_q;
        pf_valid_d = rd_valid_q;
        if (rd_valid_q) begin
          pf_data_d = ram_do_i;
        end
      end else if (rd_valid_q) begin
        sh_valid_d = 1'b1;
        sh_data_d  = ram_do_i;
      end else begin
        sh_valid_d = 1'b0;
        sh_data_d  = 8'd0;
      end
    end else if (rd_valid_q) begin
      pf_valid_d = 1'b1;
      pf_data_d  = ram_do_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      fetch_left_q <= 10'd0;
      next_addr_q  <= 9'd0;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= 9'd0;
      rd_valid_q   <= 1'b0;
      pf_valid_q   <= 1'b0;
      pf_data_q    <= 8'd0;
      sh_valid_q   <= 1'b0;
      sh_data_q    <= 8'd0;
      sh_idx_q     <= 2'd0;
      sym_left_q   <= 12'd0;
    end else begin
      busy_q       <= busy_d;
      fetch_left_q <= fetch_left_d;
      next_addr_q  <= next_addr_d;
      ram_en_q     <= ram_en_d;
      ram_addr_q   <= ram_addr_d;
      rd_valid_q   <= rd_valid_d;
      pf_valid_q   <= pf_valid_d;
      pf_data_q    <= pf_data_d;
      sh_valid_q   <= sh_valid_d;
      sh_data_q    <= sh_data_d;
      sh_idx_q     <= sh_idx_d;
      sym_left_q   <= sym_left_d;
    end
  end

  assign busy_o       = busy_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = 1'b0;
  assign ram_rst_o    = 1'b0;
  assign ram_addr_o   = ram_addr_q;
  assign dout_o       = sh_data_q[1:0];
  assign dout_valid_o = sh_valid_q;
  assign dout_last_o  = sh_valid_q & (sym_left_q == 12'd1);

endmodule
